muldiv_unit: RTL
================

# muldiv_unit

Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers, used alongside the execute stage. It generalises HI/LO handling to any data width, adds signed and unsigned variants, and adds a start/busy/done handshake, MTHI/MTLO writes and flush cancellation. The execute stage launches MULT/MULTU/DIV/DIVU here and stalls MFHI/MFLO/MTHI/MTLO while `busy` is high. The unit is iterative: one result bit per cycle.

## Interface
- `WIDTH`, default 32: operand and HI/LO width; must be even and ≥ 4.
- `clock` in 1: rising-edge clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: launch an operation; sampled only in IDLE.
- `op` in 2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a` in WIDTH: rs operand (dividend / multiplicand).
- `b` in WIDTH: rt operand (divisor / multiplier).
- `cancel` in 1: flush; aborts the in-flight operation.
- `hi_we`, `lo_we` in 1: MTHI / MTLO write enables.
- `wdata` in WIDTH: MTHI/MTLO data.
- `busy` out 1: operation in flight.
- `done` out 1: one-cycle pulse when HI/LO take a result.
- `hi`, `lo` out WIDTH: architectural HI/LO, registered.

## Operation
- **States:** IDLE, CALC, FIX.
- **IDLE:**
  - `start`=1 latches `op` and operand magnitudes (absolute values for signed ops).
  - Records `sign_q` = a[W-1]^b[W-1] and `sign_r` = a[W-1]; both are 0 for unsigned ops.
  - Clears the iteration counter and moves to CALC.
- **CALC, multiply:** radix-2 shift-add into a 2·WIDTH accumulator, one multiplier bit per cycle.
- **CALC, divide:** restoring division, one quotient bit per cycle; remainder register is WIDTH+1 bits.
- **CALC exit:** after exactly WIDTH iterations, go to FIX.
- **FIX, multiply:** product is negated (2·WIDTH-bit) if `sign_q`.
  - hi = product[2W-1:W], lo = product[W-1:0].
- **FIX, divide:** quotient is negated if `sign_q`; remainder is negated if `sign_r`.
  - lo = quotient, hi = remainder.
- **Divide by zero (b==0), signed or unsigned:** lo = all ones, hi = a (original operand). Detected at launch, applied in FIX.
- **Signed overflow (a = MIN, b = −1):** lo = MIN, hi = 0. This falls out of the magnitude algorithm and needs no special case.
- **FIX exit:** writes HI/LO, pulses `done`, returns to IDLE.
- **`cancel`:** in CALC or FIX, returns to IDLE on the next edge. HI/LO are unchanged and there is no `done`. `cancel` in IDLE has no effect, and takes priority over a simultaneous `start`.
- **`start` while busy:** ignored.
- **`hi_we`/`lo_we`:** honoured only when not busy; ignored while busy. If a write coincides with `start`, the write happens and the operation still launches.
- **Reset (async, any state):** state = IDLE, hi = lo = 0, busy = 0, done = 0, counter and datapath registers cleared.

## Timing
- `start` sampled at edge E0.
- `busy` rises after E0 and stays high through CALC (E1…E_WIDTH) and FIX.
- HI/LO update at edge E_WIDTH+1. `done` is high for the cycle after that edge, and `busy` is low in the same cycle.
- Latency from `start` to valid HI/LO is WIDTH+1 cycles (33 for WIDTH=32).
- Back-to-back operation: `start` may be asserted in the `done` cycle.
- `busy` is a pure function of state (registered). `hi`/`lo` are register outputs with no combinational path from inputs.
- MTHI/MTLO take effect at the next edge.
- Counter width is $clog2(WIDTH)+1 and it never wraps; it is compared against WIDTH−1.

## Structure
- Package `muldiv_pkg` holds:
  - `muldiv_op_e` (MULT, MULTU, DIV, DIVU encodings above);
  - `muldiv_state_e` (IDLE, CALC, FIX).
- Single module, no sub-module. The datapath is small enough that splitting it adds ports without clarity.

## Test plan
- **MULT:** a = FFFFFFFD (−3), b = 00000007 → at cycle 33, hi = FFFFFFFF, lo = FFFFFFEB; `done` 1 cycle; `busy` high 33 cycles.
- **MULTU then DIV back-to-back:**
  - MULTU a = b = FFFFFFFF → hi = FFFFFFFE, lo = 00000001.
  - Then `start` in the `done` cycle with DIV a = FFFFFFF9 (−7), b = 2 → lo = FFFFFFFD, hi = FFFFFFFF.
- **Divide by zero and overflow:**
  - DIVU a = 00000064, b = 0 → lo = FFFFFFFF, hi = 00000064.
  - DIV a = 80000000, b = FFFFFFFF → lo = 80000000, hi = 00000000.
- **Cancel and writes while busy:** preload hi = 11111111, lo = 22222222 via MTHI/MTLO, then DIV 10/3.
  - `cancel` at cycle 10 → `busy` low next cycle, no `done`, HI/LO unchanged.
  - `hi_we` during CALC is ignored.
- **Reset and simultaneous inputs:**
  - Deassert `reset_n` mid-CALC → hi = lo = 0, `busy` = 0 immediately.
  - `start` during busy is ignored.
  - `start` with `cancel` in IDLE → no launch.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package muldiv_pkg;

  // Operation select as driven by the execute stage
  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } muldiv_op_e;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } muldiv_state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One result bit per cycle on operand magnitudes; signs restored in FIX.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam int unsigned W2 = 2 * WIDTH;

  muldiv_state_e    state_q, state_d;
  muldiv_op_e       op_e;
  logic             busy_d, done_d;
  logic [WIDTH-1:0] hi_d, lo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // Multiply: {partial product, multiplier}. Divide: low half shifts dividend out, quotient in.
  logic [W2-1:0]    acc_q, acc_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] araw_q, araw_d;
  logic             is_div_q, is_div_d;
  logic             sign_q, sign_q_d;
  logic             sign_r, sign_r_d;
  logic             dz_q, dz_d;

  logic             is_signed;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH+1:0] div_shift, div_diff;
  logic             div_ge;
  logic [W2-1:0]    prod;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  // Operand decode and magnitude extraction at launch
  assign op_e      = muldiv_op_e'(op);
  assign is_signed = (op_e == OP_MULT) || (op_e == OP_DIV);
  assign a_mag     = (is_signed && a[WIDTH-1]) ? -a : a;
  assign b_mag     = (is_signed && b[WIDTH-1]) ? -b : b;

  // One shift-add step: add multiplicand when the current multiplier bit is set
  assign mul_sum = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);

  // One restoring step: trial subtract, the borrow bit decides the quotient bit
  assign div_shift = {rem_q, acc_q[WIDTH-1]};
  assign div_diff  = div_shift - (WIDTH+2)'(opnd_q);
  assign div_ge    = ~div_diff[WIDTH+1];

  // Sign restoration of the magnitude results
  assign prod    = sign_q ? -acc_q : acc_q;
  assign quo_fix = sign_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix = sign_r ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

  // Next-state, datapath and output computation
  always_comb begin
    state_d  = state_q;
    done_d   = 1'b0;
    hi_d     = hi;
    lo_d     = lo;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    opnd_d   = opnd_q;
    araw_d   = araw_q;
    is_div_d = is_div_q;
    sign_q_d = sign_q;
    sign_r_d = sign_r;
    dz_d     = dz_q;

    case (state_q)
      ST_IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start && !cancel) begin
          is_div_d = op[1];
          sign_q_d = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
          sign_r_d = is_signed && a[WIDTH-1];
          dz_d     = op[1] && (b == '0);
          araw_d   = a;
          cnt_d    = '0;
          rem_d    = '0;
          if (op[1]) begin
            acc_d  = {{WIDTH{1'b0}}, a_mag};
            opnd_d = b_mag;
          end else begin
            acc_d  = {{WIDTH{1'b0}}, b_mag};
            opnd_d = a_mag;
          end
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        if (cancel) begin
          state_d = ST_IDLE;
        end else begin
          if (is_div_q) begin
            rem_d             = div_ge ? div_diff[WIDTH:0] : div_shift[WIDTH:0];
            acc_d[WIDTH-1:0]  = {acc_q[WIDTH-2:0], div_ge};
          end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          end
          if (cnt_q == CW'(WIDTH - 1)) state_d = ST_FIX;
          else                         cnt_d   = cnt_q + CW'(1);
        end
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        if (!cancel) begin
          done_d = 1'b1;
          if (!is_div_q) begin
            hi_d = prod[W2-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
          end else if (dz_q) begin
            hi_d = araw_q;
            lo_d = '1;
          end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State, datapath and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      opnd_q   <= '0;
      araw_q   <= '0;
      is_div_q <= 1'b0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      busy     <= busy_d;
      done     <= done_d;
      hi       <= hi_d;
      lo       <= lo_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      opnd_q   <= opnd_d;
      araw_q   <= araw_d;
      is_div_q <= is_div_d;
      sign_q   <= sign_q_d;
      sign_r   <= sign_r_d;
      dz_q     <= dz_d;
    end
  end

endmodule
